// File: rtl/fir_pkg.sv
// Shared widths, types and arithmetic helper for the 4-tap FIR filter.
package fir_pkg;

    localparam int NUM_TAPS = 4;
    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int OUT_W    = DATA_W + COEF_W;

    typedef logic [DATA_W-1:0] sample_t;
    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [OUT_W-1:0]  acc_t;

    // Unsigned full-width product; both operands are widened first so the
    // multiply is evaluated at OUT_W bits and nothing is lost.
    function automatic acc_t mul_tap(input sample_t s, input coef_t c);
        return acc_t'(s) * acc_t'(c);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Enable-gated sample history for the FIR. Exposes NUM_TAPS taps: tap 0 is
// the sample being offered this cycle and taps 1..NUM_TAPS-1 are the previous
// accepted samples, newest first. Products for an accepted sample are formed
// on the same edge that shifts it in, so this window is exactly what the
// multipliers need and the oldest sample never has to be stored.
module fir_delay_line
    import fir_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  sample_t din,
    output sample_t taps [NUM_TAPS-1:0]
);

    sample_t hist [NUM_TAPS-2:0];

    // Shift the history by one accepted sample; clear it on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: this is a small register array, not a RAM, so it is
            // cleared on reset; that is what makes pre-reset history read as zero.
            for (int k = 0; k < NUM_TAPS - 1; k++) begin
                hist[k] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking, so each stage takes its neighbour's old value
            // and the whole line moves exactly one place per accepted sample.
            hist[0] <= din;
            for (int k = 1; k < NUM_TAPS - 1; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    // Present the live input as the newest tap ahead of the stored history.
    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        taps[0] = din;
        for (int k = 1; k < NUM_TAPS; k++) begin
            taps[k] = hist[k-1];
        end
    end

endmodule

// File: rtl/fir_filter.sv
// 4-tap direct-form FIR on unsigned samples with live coefficients.
// Stage 0 registers one product per tap for each accepted sample; stage 1
// sums them (wrapping at OUT_W) into signal_out with a one-cycle valid_out.
module fir_filter
    import fir_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    valid_in,
    input  coef_t   coeffs [NUM_TAPS-1:0],
    input  sample_t signal,
    output logic    valid_out,
    output acc_t    signal_out
);

    sample_t taps [NUM_TAPS-1:0];
    acc_t    prod [NUM_TAPS-1:0];
    acc_t    sum;
    logic    v1;

    fir_delay_line u_delay_line (
        .clk  (clk),
        .rst  (rst),
        .en   (valid_in),
        .din  (signal),
        .taps (taps)
    );

    // Stage 0: capture coeffs[k]*x[n-k] for an accepted sample and flag it.
    // Products are taken with the coefficients present on the accepting edge,
    // so a later coefficient change never disturbs a sample already in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod[k] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            v1 <= valid_in;
            if (valid_in) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    prod[k] <= mul_tap(taps[k], coeffs[k]);
                end
            end
        end
    end

    // Adder tree over the registered products; overflow wraps at OUT_W.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum = sum + prod[k];
        end
    end

    // Stage 1: publish the sum with a single-cycle valid; hold it otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_out  <= 1'b0;
            signal_out <= '0;
        end else begin
            valid_out <= v1;
            if (v1) begin
                signal_out <= sum;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset, streaming, gaps, wrap-around,
// reset mid-stream and live coefficient change, each with hand-computed
// expected outputs per clock.
module tb_fir_filter;
    import fir_pkg::*;

    logic    clk;
    logic    rst;
    logic    valid_in;
    coef_t   coeffs [NUM_TAPS-1:0];
    sample_t signal;
    logic    valid_out;
    acc_t    signal_out;

    int checks   = 0;
    int failures = 0;

    fir_filter dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .coeffs     (coeffs),
        .signal     (signal),
        .valid_out  (valid_out),
        .signal_out (signal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then wait past the next rising edge.
    task automatic cycle(input logic r, input logic v, input sample_t s);
        rst      = r;
        valid_in = v;
        signal   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic set_coeffs(input coef_t c0, input coef_t c1, input coef_t c2, input coef_t c3);
        coeffs[0] = c0;
        coeffs[1] = c1;
        coeffs[2] = c2;
        coeffs[3] = c3;
    endtask

    task automatic apply_reset();
        cycle(1'b0, 1'b0, 16'd0);
        cycle(1'b0, 1'b0, 16'd0);
        rst = 1'b1;
    endtask

    // Reset held for two cycles with valid_in asserted: outputs stay at zero.
    task automatic test_reset();
        set_coeffs(16'd2, 16'd6, 16'd5, 16'd6);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 16'd123);
            checks++;
            if (valid_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid[%0d]: got %b expected 0", i, valid_out);
            end
            checks++;
            if (signal_out !== 32'd0) begin
                failures++;
                $display("FAIL reset_out[%0d]: got %0d expected 0", i, signal_out);
            end
        end
        rst = 1'b1;
    endtask

    // Four samples back to back, then idle: output holds after the burst.
    task automatic test_back_to_back();
        logic        vin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] sin [6] = '{16'd10, 16'd20, 16'd15, 16'd5, 16'd0, 16'd0};
        logic        ev  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eo  [6] = '{32'd0, 32'd20, 32'd100, 32'd200, 32'd260, 32'd260};
        apply_reset();
        set_coeffs(16'd2, 16'd6, 16'd5, 16'd6);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vin[i], sin[i]);
            checks++;
            if (valid_out !== ev[i]) begin
                failures++;
                $display("FAIL b2b_valid[%0d]: got %b expected %b", i, valid_out, ev[i]);
            end
            checks++;
            if (signal_out !== eo[i]) begin
                failures++;
                $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, signal_out, eo[i]);
            end
        end
    endtask

    // Gaps between samples: junk on signal while idle must not enter history.
    task automatic test_gaps();
        logic        vin [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] sin [8] = '{16'd10, 16'd999, 16'd20, 16'd777, 16'd555, 16'd15, 16'd333, 16'd0};
        logic        ev  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] eo  [8] = '{32'd0, 32'd20, 32'd20, 32'd100, 32'd100, 32'd100, 32'd200, 32'd200};
        apply_reset();
        set_coeffs(16'd2, 16'd6, 16'd5, 16'd6);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vin[i], sin[i]);
            checks++;
            if (valid_out !== ev[i]) begin
                failures++;
                $display("FAIL gap_valid[%0d]: got %b expected %b", i, valid_out, ev[i]);
            end
            checks++;
            if (signal_out !== eo[i]) begin
                failures++;
                $display("FAIL gap_out[%0d]: got %0d expected %0d", i, signal_out, eo[i]);
            end
        end
    endtask

    // Full-scale samples and coefficients: the 4-term sum wraps at 32 bits.
    task automatic test_wrap();
        logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] eo [5] = '{32'h0, 32'hFFFE0001, 32'hFFFC0002, 32'hFFFA0003, 32'hFFF80004};
        apply_reset();
        set_coeffs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, (i < 4), 16'hFFFF);
            checks++;
            if (valid_out !== ev[i]) begin
                failures++;
                $display("FAIL wrap_valid[%0d]: got %b expected %b", i, valid_out, ev[i]);
            end
            checks++;
            if (signal_out !== eo[i]) begin
                failures++;
                $display("FAIL wrap_out[%0d]: got %h expected %h", i, signal_out, eo[i]);
            end
        end
    endtask

    // Reset after two samples discards the in-flight result and the history;
    // reset also overrides a valid_in presented on the same edge.
    task automatic test_reset_midstream();
        logic        r   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        vin [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] sin [6] = '{16'd10, 16'd20, 16'd15, 16'd0, 16'd10, 16'd0};
        logic        ev  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] eo  [6] = '{32'd0, 32'd20, 32'd0, 32'd0, 32'd0, 32'd20};
        apply_reset();
        set_coeffs(16'd2, 16'd6, 16'd5, 16'd6);
        for (int i = 0; i < 6; i++) begin
            cycle(r[i], vin[i], sin[i]);
            checks++;
            if (valid_out !== ev[i]) begin
                failures++;
                $display("FAIL rstmid_valid[%0d]: got %b expected %b", i, valid_out, ev[i]);
            end
            checks++;
            if (signal_out !== eo[i]) begin
                failures++;
                $display("FAIL rstmid_out[%0d]: got %0d expected %0d", i, signal_out, eo[i]);
            end
        end
    endtask

    // Coefficients switch to all ones as the third sample is offered; the
    // second sample's products are already registered and keep old weights.
    task automatic test_coeff_change();
        logic        vin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] sin [6] = '{16'd10, 16'd20, 16'd15, 16'd5, 16'd0, 16'd0};
        logic        ev  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] eo  [6] = '{32'd0, 32'd20, 32'd100, 32'd45, 32'd50, 32'd50};
        apply_reset();
        set_coeffs(16'd2, 16'd6, 16'd5, 16'd6);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                set_coeffs(16'd1, 16'd1, 16'd1, 16'd1);
            end
            cycle(1'b1, vin[i], sin[i]);
            checks++;
            if (valid_out !== ev[i]) begin
                failures++;
                $display("FAIL coef_valid[%0d]: got %b expected %b", i, valid_out, ev[i]);
            end
            checks++;
            if (signal_out !== eo[i]) begin
                failures++;
                $display("FAIL coef_out[%0d]: got %0d expected %0d", i, signal_out, eo[i]);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        valid_in = 1'b0;
        signal   = '0;
        set_coeffs(16'd0, 16'd0, 16'd0, 16'd0);

        test_reset();
        test_back_to_back();
        test_gaps();
        test_wrap();
        test_reset_midstream();
        test_coeff_change();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
